register_file_sb: RTL and testbench

REGISTER_FILE_SB -- requirements
Module: register_file_sb

---
 rtl/register_file_sb_if.sv | 30 +++
 rtl/register_file_sb.sv | 127 ++++++++++++
 tb/tb_register_file_sb.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/register_file_sb_if.sv
// Register file bus: read ports, write port, issue strobe and clear handshake.
// The register file takes the slave side; the client drives selects and strobes.
interface register_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]     rsel;
  logic [NRD*DATA_W-1:0] rdat;
  logic [NRD-1:0]        rbusy;
  logic                  WEN;
  logic [AW-1:0]         wsel;
  logic [DATA_W-1:0]     wdat;
  logic                  iss_en;
  logic [AW-1:0]         iss_sel;
  logic                  clr_req;
  logic                  clr_busy;

  modport master (
    output rsel, WEN, wsel, wdat, iss_en, iss_sel, clr_req,
    input  rdat, rbusy, clr_busy
  );

  modport slave (
    input  rsel, WEN, wsel, wdat, iss_en, iss_sel, clr_req,
    output rdat, rbusy, clr_busy
  );
endinterface

// File: rtl/register_file_sb.sv
// Scoreboarded register file: NRD combinational read ports with write bypass,
// per-register pending bits, and a one-register-per-cycle clear sweep.

module register_file_sb_rdport #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5
) (
  input  logic                          rst_n_i,
  input  logic [AW-1:0]                 rsel_i,
  input  logic [NREGS-1:0][DATA_W-1:0]  regs_i,
  input  logic [NREGS-1:0]              pend_i,
  input  logic                          byp_en_i,
  input  logic [AW-1:0]                 wsel_i,
  input  logic [DATA_W-1:0]             wdat_i,
  output logic [DATA_W-1:0]             rdat_o,
  output logic                          rbusy_o
);
  // Outputs are forced low while reset is held, even if a write is being presented.
  always_comb begin
    rdat_o  = '0;
    rbusy_o = 1'b0;
    if (rst_n_i) begin
      if (byp_en_i && (wsel_i == rsel_i)) begin
        rdat_o = wdat_i;
      end else begin
        rdat_o  = regs_i[rsel_i];
        rbusy_o = pend_i[rsel_i];
      end
    end
  end
endmodule

module register_file_sb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  register_file_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t                       state_q, state_d;
  logic [AW-1:0]                idx_q, idx_d;
  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0]             pend_q;
  logic                         sweep;
  logic                         wr_ok;
  logic                         iss_ok;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep starts at index 1 (register 0 is hardwired) and ends after NREGS-1.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = AW'(1);
        if (bus.clr_req) state_d = SWEEP;
      end
      SWEEP: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREGS-1)) begin
          state_d = IDLE;
          idx_d   = AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sweep        = (state_q == SWEEP);
    bus.clr_busy = sweep;
  end

  assign wr_ok  = !sweep && bus.WEN    && (bus.wsel    != '0);
  assign iss_ok = !sweep && bus.iss_en && (bus.iss_sel != '0);

  // Issue is applied after the write so a same-edge issue leaves the register pending.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      regs_q <= '0;
      pend_q <= '0;
    end else if (sweep) begin
      regs_q[idx_q] <= '0;
      pend_q[idx_q] <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs_q[bus.wsel] <= bus.wdat;
        pend_q[bus.wsel] <= 1'b0;
      end
      if (iss_ok) pend_q[bus.iss_sel] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    register_file_sb_rdport #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .AW     (AW)
    ) u_rd (
      .rst_n_i  (nRST),
      .rsel_i   (bus.rsel[i*AW +: AW]),
      .regs_i   (regs_q),
      .pend_i   (pend_q),
      .byp_en_i (wr_ok),
      .wsel_i   (bus.wsel),
      .wdat_i   (bus.wdat),
      .rdat_o   (bus.rdat[i*DATA_W +: DATA_W]),
      .rbusy_o  (bus.rbusy[i])
    );
  end
endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a negedge monitor
// drains the queue against the default (32/32/2) and the 64/16/3 instances.
module tb_register_file_sb;
  logic        CLK = 1'b0;
  logic        nRST;
  logic [4:0]  rs [3];
  logic        we, ie, cr;
  logic [4:0]  ws, is_;
  logic [63:0] wd;

  always #5 CLK = ~CLK;

  register_file_sb_if #(.DATA_W(32), .NREGS(32), .NRD(2)) b0();
  register_file_sb_if #(.DATA_W(64), .NREGS(16), .NRD(3)) b1();

  assign b0.rsel    = {rs[1], rs[0]};
  assign b0.WEN     = we;
  assign b0.wsel    = ws;
  assign b0.wdat    = wd[31:0];
  assign b0.iss_en  = ie;
  assign b0.iss_sel = is_;
  assign b0.clr_req = cr;

  assign b1.rsel    = {rs[2][3:0], rs[1][3:0], rs[0][3:0]};
  assign b1.WEN     = we;
  assign b1.wsel    = ws[3:0];
  assign b1.wdat    = wd;
  assign b1.iss_en  = ie;
  assign b1.iss_sel = is_[3:0];
  assign b1.clr_req = cr;

  register_file_sb #(.DATA_W(32), .NREGS(32), .NRD(2)) u_dut0 (.CLK(CLK), .nRST(nRST), .bus(b0));
  register_file_sb #(.DATA_W(64), .NREGS(16), .NRD(3)) u_dut1 (.CLK(CLK), .nRST(nRST), .bus(b1));

  typedef struct {
    string       name;
    int          d;
    int          kind;   // 0 rdat, 1 rbusy, 2 clr_busy
    int          port;
    logic [63:0] exp;
  } chk_t;

  chk_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_d;
  int   cur_nrd;

  function automatic logic [63:0] msk(logic [63:0] v);
    return (cur_d == 0) ? {32'h0, v[31:0]} : v;
  endfunction

  function automatic logic [63:0] fill(int r);
    return msk(64'hA5A5_0000_0000_0000 | (64'(r) * 64'h0001_0001_0011));
  endfunction

  function automatic void push(string nm, int kind, int p, logic [63:0] v);
    chk_t c;
    c.name = nm; c.d = cur_d; c.kind = kind; c.port = p; c.exp = v;
    sbq.push_back(c);
  endfunction

  function automatic void exp_port(string nm, int p, logic [63:0] dat, logic bsy);
    push(nm, 0, p, msk(dat));
    push(nm, 1, p, 64'(bsy));
  endfunction

  function automatic void exp_all(string nm, logic [63:0] dat, logic bsy);
    for (int p = 0; p < cur_nrd; p++) exp_port(nm, p, dat, bsy);
  endfunction

  function automatic void exp_clr(string nm, logic v);
    push(nm, 2, 0, 64'(v));
  endfunction

  // Monitor: whatever the stimulus queued for this cycle is compared mid-cycle.
  always @(negedge CLK) begin
    chk_t        c;
    logic [63:0] act;
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      case (c.kind)
        0:       act = (c.d == 0) ? {32'h0, b0.rdat[c.port*32 +: 32]} : b1.rdat[c.port*64 +: 64];
        1:       act = (c.d == 0) ? 64'(b0.rbusy[c.port]) : 64'(b1.rbusy[c.port]);
        default: act = (c.d == 0) ? 64'(b0.clr_busy) : 64'(b1.clr_busy);
      endcase
      n_cmp++;
      if (act !== c.exp) begin
        n_bad++;
        $display("FAIL %s dut%0d kind%0d port%0d: got %h want %h", c.name, c.d, c.kind, c.port, act, c.exp);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    we = 1'b0; ie = 1'b0; cr = 1'b0; ws = '0; is_ = '0; wd = '0;
  endtask

  task automatic set_rs(int r);
    for (int p = 0; p < 3; p++) rs[p] = 5'(r);
  endtask

  task automatic run(int d, int nregs, int nrd);
    cur_d = d; cur_nrd = nrd;
    // reset: outputs low even with a bypass-eligible write presented
    nRST = 1'b0; we = 1'b1; ws = 5'd5; wd = 64'h1111; set_rs(5); ie = 1'b0; cr = 1'b0; is_ = '0;
    exp_all("rst_out", 64'h0, 1'b0); exp_clr("rst_clr", 1'b0);
    step(); step();
    nRST = 1'b1; idle_in(); step();

    we = 1'b1; ws = 5'd5; wd = 64'hCAFE0000_DEADBEEF; set_rs(3);
    exp_all("w5_other", 64'h0, 1'b0); step();
    idle_in(); set_rs(5); exp_all("rd5", 64'hCAFE0000_DEADBEEF, 1'b0); step();
    we = 1'b1; ws = 5'd0; wd = 64'h1234; set_rs(0); exp_all("w0_nobyp", 64'h0, 1'b0); step();
    idle_in(); exp_all("rd0", 64'h0, 1'b0); step();

    we = 1'b1; ws = 5'd7; wd = 64'h1234; set_rs(7); exp_all("byp7", 64'h1234, 1'b0); step();
    idle_in(); exp_all("rd7", 64'h1234, 1'b0); step();

    ie = 1'b1; is_ = 5'd9; set_rs(9); exp_all("iss9_same", 64'h0, 1'b0); step();
    idle_in(); exp_all("pend9", 64'h0, 1'b1); step();
    we = 1'b1; ws = 5'd9; wd = 64'h99; exp_all("byp9_clr", 64'h99, 1'b0); step();
    idle_in(); exp_all("rd9", 64'h99, 1'b0); step();
    we = 1'b1; ws = 5'd9; wd = 64'hAA; ie = 1'b1; is_ = 5'd9; exp_all("wi9_byp", 64'hAA, 1'b0); step();
    idle_in(); exp_all("wi9_pend", 64'hAA, 1'b1); step();
    ie = 1'b1; is_ = 5'd0; step();
    idle_in(); set_rs(0); exp_all("iss0", 64'h0, 1'b0); step();

    rs[0] = 5'd5; rs[1] = 5'd9; rs[2] = 5'd7;
    exp_port("mix0", 0, 64'hCAFE0000_DEADBEEF, 1'b0);
    exp_port("mix1", 1, 64'hAA, 1'b1);
    if (nrd > 2) exp_port("mix2", 2, 64'h1234, 1'b0);
    step();

    for (int r = 1; r < nregs; r++) begin
      we = 1'b1; ws = 5'(r); wd = fill(r); step();
    end
    idle_in(); ie = 1'b1; is_ = 5'd3; step();
    idle_in(); set_rs(3); exp_all("pend3", fill(3), 1'b1); step();

    // clear request with a same-edge write and issue, both applied then swept
    cr = 1'b1; we = 1'b1; ws = 5'd4; wd = 64'h4444; ie = 1'b1; is_ = 5'd6;
    exp_clr("clr_edge", 1'b0); step();
    for (int k = 0; k < nregs; k++) begin
      idle_in();
      if (k < nregs-1) begin
        we = 1'b1; ws = 5'd2; wd = 64'hBAD; ie = 1'b1; is_ = 5'd2; cr = 1'b1;
      end
      exp_clr("sweep_busy", k < nregs-1);
      if (k == 0) begin
        rs[0] = 5'd4; rs[1] = 5'd6;
        exp_port("clr_w4", 0, 64'h4444, 1'b0);
        exp_port("clr_i6", 1, fill(6), 1'b1);
      end
      if (k == 1) begin
        rs[0] = 5'd3; rs[1] = 5'd2;
        exp_port("sw_rd3", 0, fill(3), 1'b1);
        exp_port("sw_nobyp", 1, fill(2), 1'b0);
      end
      step();
    end
    idle_in();
    for (int r = 0; r < nregs; r++) begin
      set_rs(r); exp_all("post_clr", 64'h0, 1'b0); step();
    end

    // reset landing in the middle of a sweep (index 12)
    we = 1'b1; ws = 5'd13; wd = 64'h1313; step();
    idle_in(); cr = 1'b1; step();
    idle_in();
    for (int k = 0; k < 11; k++) begin
      exp_clr("sw40_busy", 1'b1); step();
    end
    nRST = 1'b0; set_rs(13); we = 1'b1; ws = 5'd13; wd = 64'h7777;
    exp_all("rst_mid", 64'h0, 1'b0); exp_clr("rst_mid_clr", 1'b0); step();
    nRST = 1'b1; we = 1'b1; ws = 5'd12; wd = 64'h1212; set_rs(12);
    exp_all("post_rst_byp", 64'h1212, 1'b0); exp_clr("post_rst_clr", 1'b0); step();
    idle_in(); rs[0] = 5'd12; rs[1] = 5'd13;
    exp_port("post_rst_w12", 0, 64'h1212, 1'b0);
    exp_port("post_rst_r13", 1, 64'h0, 1'b0);
    exp_clr("no_resume", 1'b0);
    step();
  endtask

  initial begin
    idle_in(); set_rs(0); nRST = 1'b0;
    run(0, 32, 2);
    run(1, 16, 3);
    @(negedge CLK); #1;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d checks left unconsumed, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end
endmodule
